// File: rtl/evm_tally.sv
// rtl/evm_tally.sv - poll-session voting tally with saturating counters and winner scan
// Ballot-gated vote counting, sequential max scan in TALLY, results held in CLOSED.
module evm_tally #(
    parameter int N_CAND    = 4,
    parameter int CNT_W     = 16,
    parameter int SEL_W     = $clog2(N_CAND),
    parameter int MAX_VOTES = 1000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    open_poll,
    input  logic                    close_poll,
    input  logic                    clear,
    input  logic                    ballot_en,
    input  logic                    vote_valid,
    input  logic [SEL_W-1:0]        vote_sel,
    output logic                    vote_ready,
    output logic [N_CAND*CNT_W-1:0] result_flat,
    output logic [CNT_W-1:0]        total,
    output logic [SEL_W-1:0]        winner,
    output logic                    winner_valid,
    output logic                    tie,
    output logic [2:0]              state,
    output logic                    err_invalid
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_OPEN   = 3'd1,
        S_ARMED  = 3'd2,
        S_TALLY  = 3'd3,
        S_CLOSED = 3'd4
    } state_t;

    localparam logic [SEL_W:0]   N_CAND_W = (SEL_W+1)'(N_CAND);
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_CAND - 1);

    state_t           st, st_nx;
    logic [CNT_W-1:0] cnt [N_CAND];
    logic [CNT_W-1:0] total_r, total_nx, max_r, cur;
    logic [SEL_W-1:0] idx, win_r;
    logic             tie_r, wv_r, err_r;
    logic             legal, accept, bad, hit_max, last;

    always_comb begin
        legal    = ({1'b0, vote_sel} < N_CAND_W);
        accept   = (st == S_ARMED) && vote_valid && legal;
        bad      = (st == S_ARMED) && vote_valid && !legal;
        total_nx = (total_r == '1) ? total_r : total_r + 1'b1;
        hit_max  = accept && (32'(total_nx) == MAX_VOTES);
        last     = (idx == LAST_IDX);
        cur      = cnt[idx];
    end

    // close_poll wins over a same-cycle ballot; an accepted vote is still counted first
    always_comb begin
        st_nx = st;
        case (st)
            S_IDLE:   if (open_poll) st_nx = S_OPEN;
            S_OPEN:   if (close_poll) st_nx = S_TALLY;
                      else if (ballot_en) st_nx = S_ARMED;
            S_ARMED:  if (close_poll || hit_max) st_nx = S_TALLY;
                      else if (accept) st_nx = S_OPEN;
            S_TALLY:  if (last) st_nx = S_CLOSED;
            S_CLOSED: if (clear) st_nx = S_IDLE;
            default:  st_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st      <= S_IDLE;
            for (int k = 0; k < N_CAND; k++) cnt[k] <= '0;
            total_r <= '0;
            max_r   <= '0;
            idx     <= '0;
            win_r   <= '0;
            tie_r   <= 1'b0;
            wv_r    <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            st    <= st_nx;
            err_r <= bad;
            if (accept) begin
                if (cnt[vote_sel] != '1) cnt[vote_sel] <= cnt[vote_sel] + 1'b1;
                total_r <= total_nx;
            end
            if (clear && (st == S_IDLE || st == S_CLOSED)) begin
                for (int k = 0; k < N_CAND; k++) cnt[k] <= '0;
                total_r <= '0;
                win_r   <= '0;
                tie_r   <= 1'b0;
                wv_r    <= 1'b0;
            end
            // First scanned candidate seeds the running max so all-zero counts end in a tie
            if (st == S_TALLY) begin
                idx <= idx + 1'b1;
                if (idx == '0) begin
                    max_r <= cur;
                    win_r <= '0;
                    tie_r <= 1'b0;
                end else if (cur > max_r) begin
                    max_r <= cur;
                    win_r <= idx;
                    tie_r <= 1'b0;
                end else if (cur == max_r) begin
                    tie_r <= 1'b1;
                end
                if (last) wv_r <= 1'b1;
            end else begin
                idx <= '0;
            end
        end
    end

    for (genvar k = 0; k < N_CAND; k++) begin : g_flat
        assign result_flat[k*CNT_W +: CNT_W] = cnt[k];
    end

    assign vote_ready   = (st == S_ARMED);
    assign total        = total_r;
    assign winner       = win_r;
    assign winner_valid = wv_r;
    assign tie          = tie_r;
    assign state        = st;
    assign err_invalid  = err_r;

endmodule

// File: tb/tb_evm_tally.sv
// tb/tb_evm_tally.sv - scoreboard bench for evm_tally
// Two instances: A (N_CAND=4, CNT_W=4, MAX_VOTES=15) and B (N_CAND=3, CNT_W=4, MAX_VOTES=20).
module tb_evm_tally;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, open_poll, close_poll, clear, ballot_en, vote_valid;
    logic [1:0] vote_sel;

    logic        a_ready, a_wv, a_tie, a_err;
    logic [15:0] a_flat;
    logic [3:0]  a_total;
    logic [1:0]  a_winner;
    logic [2:0]  a_state;

    logic        b_ready, b_wv, b_tie, b_err;
    logic [11:0] b_flat;
    logic [3:0]  b_total;
    logic [1:0]  b_winner;
    logic [2:0]  b_state;

    evm_tally #(.N_CAND(4), .CNT_W(4), .MAX_VOTES(15)) dut_a (
        .clk(clk), .reset_n(reset_n), .open_poll(open_poll), .close_poll(close_poll),
        .clear(clear), .ballot_en(ballot_en), .vote_valid(vote_valid), .vote_sel(vote_sel),
        .vote_ready(a_ready), .result_flat(a_flat), .total(a_total), .winner(a_winner),
        .winner_valid(a_wv), .tie(a_tie), .state(a_state), .err_invalid(a_err)
    );

    evm_tally #(.N_CAND(3), .CNT_W(4), .MAX_VOTES(20)) dut_b (
        .clk(clk), .reset_n(reset_n), .open_poll(open_poll), .close_poll(close_poll),
        .clear(clear), .ballot_en(ballot_en), .vote_valid(vote_valid), .vote_sel(vote_sel),
        .vote_ready(b_ready), .result_flat(b_flat), .total(b_total), .winner(b_winner),
        .winner_valid(b_wv), .tie(b_tie), .state(b_state), .err_invalid(b_err)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];
    int          ma[4];
    int          mb[3];

    function automatic logic [31:0] pack_a();
        logic [31:0] v = 0;
        for (int k = 0; k < 4; k++) v |= 32'(ma[k]) << (4*k);
        return v;
    endfunction

    function automatic logic [31:0] pack_b();
        logic [31:0] v = 0;
        for (int k = 0; k < 3; k++) v |= 32'(mb[k]) << (4*k);
        return v;
    endfunction

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        {open_poll, close_poll, clear, ballot_en, vote_valid} = '0;
        vote_sel = 2'd0;
        reset_n  = 1'b0;
        cyc(2);
        reset_n  = 1'b1;
        cyc(1);
        for (int k = 0; k < 4; k++) ma[k] = 0;
        for (int k = 0; k < 3; k++) mb[k] = 0;
        exp_q.delete();
    endtask

    task automatic open_session();
        open_poll = 1'b1;
        cyc(1);
        open_poll = 1'b0;
    endtask

    task automatic ballot_vote(input int sel);
        ballot_en  = 1'b1;
        cyc(1);
        ballot_en  = 1'b0;
        vote_valid = 1'b1;
        vote_sel   = 2'(sel);
        cyc(1);
        vote_valid = 1'b0;
    endtask

    task automatic wait_valid(input bit use_b, output int n);
        n = 0;
        while (!(use_b ? b_wv : a_wv) && n < 20) begin
            cyc(1);
            n++;
        end
    endtask

    task automatic test_reset();
        logic [31:0] e;
        do_reset();
        n_cmp++; if (a_state !== 3'd0 || a_flat !== 16'h0 || a_total !== 4'd0) begin n_bad++; $display("FAIL reset_a state=%0d flat=%h total=%0d required 0/0/0", a_state, a_flat, a_total); end
        n_cmp++; if ({a_winner, a_tie, a_wv, a_err, a_ready} !== 6'b0) begin n_bad++; $display("FAIL reset_a_flags got %b required 000000", {a_winner, a_tie, a_wv, a_err, a_ready}); end
        open_session();
        foreach (ma[k]) ma[k] = 0;
        ma[0] = 3; ma[1] = 1; ma[3] = 2;
        exp_q.push_back(pack_a());
        ballot_vote(0); ballot_vote(0); ballot_vote(0); ballot_vote(1); ballot_vote(3); ballot_vote(3);
        e = exp_q.pop_front();
        n_cmp++; if (32'(a_flat) !== e) begin n_bad++; $display("FAIL pre_reset_counts got %h required %h", a_flat, e); end
        reset_n = 1'b0;
        #1;
        n_cmp++; if (a_flat !== 16'h0 || a_state !== 3'd0 || a_total !== 4'd0) begin n_bad++; $display("FAIL async_reset flat=%h state=%0d total=%0d required 0", a_flat, a_state, a_total); end
        cyc(1);
        reset_n    = 1'b1;
        vote_valid = 1'b1;
        vote_sel   = 2'd0;
        cyc(2);
        vote_valid = 1'b0;
        n_cmp++; if (a_flat !== 16'h0 || a_state !== 3'd0) begin n_bad++; $display("FAIL idle_vote_ignored flat=%h state=%0d required 0", a_flat, a_state); end
    endtask

    task automatic test_basic();
        int          sels[5] = '{2, 2, 1, 2, 3};
        int          n;
        logic [31:0] e;
        do_reset();
        open_session();
        foreach (sels[i]) begin
            ma[sels[i]]++;
            exp_q.push_back(pack_a());
            ballot_vote(sels[i]);
            e = exp_q.pop_front();
            n_cmp++; if (32'(a_flat) !== e) begin n_bad++; $display("FAIL basic_vote%0d got %h required %h", i, a_flat, e); end
        end
        exp_q.push_back(32'd5); exp_q.push_back(32'd2); exp_q.push_back(32'd0);
        close_poll = 1'b1;
        cyc(1);
        close_poll = 1'b0;
        n_cmp++; if (a_state !== 3'd3) begin n_bad++; $display("FAIL basic_tally_state got %0d required 3", a_state); end
        wait_valid(1'b0, n);
        n_cmp++; if (n !== 4) begin n_bad++; $display("FAIL basic_latency got %0d required 4", n); end
        e = exp_q.pop_front();
        n_cmp++; if (32'(a_total) !== e) begin n_bad++; $display("FAIL basic_total got %0d required %0d", a_total, e); end
        e = exp_q.pop_front();
        n_cmp++; if (32'(a_winner) !== e) begin n_bad++; $display("FAIL basic_winner got %0d required %0d", a_winner, e); end
        e = exp_q.pop_front();
        n_cmp++; if (32'(a_tie) !== e) begin n_bad++; $display("FAIL basic_tie got %0d required %0d", a_tie, e); end
        n_cmp++; if (a_flat !== 16'h1310 || a_state !== 3'd4) begin n_bad++; $display("FAIL basic_closed flat=%h state=%0d required 1310/4", a_flat, a_state); end
    endtask

    task automatic test_ballot();
        do_reset();
        open_session();
        ballot_en = 1'b1;
        cyc(1);
        ballot_en = 1'b0;
        n_cmp++; if (a_ready !== 1'b1 || a_state !== 3'd2) begin n_bad++; $display("FAIL armed ready=%0d state=%0d required 1/2", a_ready, a_state); end
        vote_valid = 1'b1;
        vote_sel   = 2'd1;
        cyc(1);
        n_cmp++; if (a_ready !== 1'b0) begin n_bad++; $display("FAIL ready_after_accept got %0d required 0", a_ready); end
        cyc(2);
        vote_valid = 1'b0;
        n_cmp++; if (a_flat !== 16'h0010 || a_total !== 4'd1) begin n_bad++; $display("FAIL one_ballot flat=%h total=%0d required 0010/1", a_flat, a_total); end
        ballot_en = 1'b1; cyc(1); ballot_en = 1'b0; cyc(1);
        ballot_en = 1'b1; cyc(1); ballot_en = 1'b0;
        vote_valid = 1'b1;
        cyc(3);
        vote_valid = 1'b0;
        n_cmp++; if (a_flat !== 16'h0020 || a_total !== 4'd2) begin n_bad++; $display("FAIL no_stacking flat=%h total=%0d required 0020/2", a_flat, a_total); end
    endtask

    task automatic test_tie_invalid();
        int          sels[4] = '{0, 2, 0, 2};
        int          n;
        logic [31:0] e;
        do_reset();
        open_session();
        foreach (sels[i]) begin
            mb[sels[i]]++;
            ballot_vote(sels[i]);
        end
        exp_q.push_back(pack_b());
        ballot_en = 1'b1; cyc(1); ballot_en = 1'b0;
        vote_valid = 1'b1;
        vote_sel   = 2'd3;
        cyc(1);
        vote_valid = 1'b0;
        n_cmp++; if (b_err !== 1'b1 || b_state !== 3'd2 || b_total !== 4'd4) begin n_bad++; $display("FAIL invalid_sel err=%0d state=%0d total=%0d required 1/2/4", b_err, b_state, b_total); end
        cyc(1);
        n_cmp++; if (b_err !== 1'b0 || b_state !== 3'd2) begin n_bad++; $display("FAIL err_one_cycle err=%0d state=%0d required 0/2", b_err, b_state); end
        close_poll = 1'b1; cyc(1); close_poll = 1'b0;
        wait_valid(1'b1, n);
        n_cmp++; if (n !== 3) begin n_bad++; $display("FAIL tie_latency got %0d required 3", n); end
        e = exp_q.pop_front();
        n_cmp++; if (32'(b_flat) !== e) begin n_bad++; $display("FAIL tie_counts got %h required %h", b_flat, e); end
        n_cmp++; if (b_winner !== 2'd0 || b_tie !== 1'b1) begin n_bad++; $display("FAIL tie_result winner=%0d tie=%0d required 0/1", b_winner, b_tie); end
    endtask

    task automatic test_autoclose();
        int n;
        do_reset();
        open_session();
        repeat (15) ballot_vote(1);
        n_cmp++; if (a_state !== 3'd3 || a_flat !== 16'h00f0 || a_total !== 4'd15) begin n_bad++; $display("FAIL autoclose state=%0d flat=%h total=%0d required 3/00f0/15", a_state, a_flat, a_total); end
        wait_valid(1'b0, n);
        n_cmp++; if (n !== 4 || a_winner !== 2'd1 || a_tie !== 1'b0) begin n_bad++; $display("FAIL autoclose_result n=%0d winner=%0d tie=%0d required 4/1/0", n, a_winner, a_tie); end
    endtask

    task automatic test_saturation();
        do_reset();
        open_session();
        repeat (17) ballot_vote(0);
        n_cmp++; if (b_flat !== 12'h00f || b_total !== 4'd15 || b_state !== 3'd1) begin n_bad++; $display("FAIL saturate flat=%h total=%0d state=%0d required 00f/15/1", b_flat, b_total, b_state); end
    endtask

    task automatic test_simultaneous();
        int n;
        do_reset();
        open_session();
        ballot_en = 1'b1; cyc(1); ballot_en = 1'b0;
        vote_valid = 1'b1;
        vote_sel   = 2'd3;
        close_poll = 1'b1;
        cyc(1);
        {vote_valid, close_poll} = 2'b00;
        n_cmp++; if (a_flat !== 16'h1000 || a_state !== 3'd3) begin n_bad++; $display("FAIL vote_and_close flat=%h state=%0d required 1000/3", a_flat, a_state); end
        wait_valid(1'b0, n);
        open_poll = 1'b1; cyc(1); open_poll = 1'b0;
        n_cmp++; if (a_state !== 3'd4 || a_winner !== 2'd3) begin n_bad++; $display("FAIL closed_hold state=%0d winner=%0d required 4/3", a_state, a_winner); end
        clear = 1'b1; cyc(1); clear = 1'b0;
        n_cmp++; if (a_state !== 3'd0 || a_flat !== 16'h0 || a_total !== 4'd0 || a_wv !== 1'b0) begin n_bad++; $display("FAIL clear state=%0d flat=%h total=%0d wv=%0d required 0", a_state, a_flat, a_total, a_wv); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ballot();
        test_tie_invalid();
        test_autoclose();
        test_saturation();
        test_simultaneous();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
